// File: rtl/abp_pkg.sv
// abp_pkg: ABP framing constants and sender state type shared by sender and receiver
package abp_pkg;
  localparam int FRAME_BYTES = 64;
  localparam int VALUE_BYTES = 8;
  localparam int SEQ_BYTE_IDX = 63;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} abp_tx_state_t;
endpackage

// File: rtl/abp_ack_timer.sv
// abp_ack_timer: acknowledgement timeout counter
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero, wins over en
//   en         : advance the count this cycle
//   expire     : en while the count sits at TIMEOUT_CYCLES-1
module abp_ack_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] count;
  assign expire = en && count == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : en ? count + 16'd1 : count;
endmodule

// File: rtl/abp_sender_transmitter.sv
// abp_sender_transmitter: frames a 64-bit value into a 64-byte ABP packet, holds it until acked, resends on timeout
//   aclk, aresetn           : clock, asynchronous active-low reset
//   send_valid/ready/value  : value hand-off from the local sender
//   m_axis_*                : AXI4-Stream byte output, tlast on byte 63
//   ack_valid, ack_bit      : acknowledgement strobe and its sequence bit
//   busy, seq_bit, done     : frame outstanding, current alternating bit, matching-ack pulse
//   retry_count             : saturating retransmission count for the current value
module abp_sender_transmitter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RETRY_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   send_valid,
  output logic                   send_ready,
  input  logic [63:0]            send_value,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [7:0]             m_axis_tdata,
  input  logic                   ack_valid,
  input  logic                   ack_bit,
  output logic                   busy,
  output logic                   seq_bit,
  output logic                   done,
  output logic [RETRY_WIDTH-1:0] retry_count
);
  import abp_pkg::*;
  localparam int IW = $clog2(FRAME_BYTES);
  abp_tx_state_t state, state_nxt;
  logic [IW-1:0] byte_idx;
  logic [63:0] value;
  logic ready_en, accept, beat, last_beat, ack_match, expire, retx;
  // ready_en keeps send_ready low for the first cycle after reset release
  assign busy = state != IDLE;
  assign send_ready = ready_en && !busy;
  assign accept = send_valid && send_ready;
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tlast = m_axis_tvalid && byte_idx == IW'(SEQ_BYTE_IDX);
  assign m_axis_tdata = !m_axis_tvalid ? 8'h00 :
                        byte_idx < IW'(VALUE_BYTES) ? value[{byte_idx[2:0], 3'b000} +: 8] :
                        {7'b0, m_axis_tlast && seq_bit};
  assign beat = m_axis_tvalid && m_axis_tready;
  assign last_beat = beat && m_axis_tlast;
  assign ack_match = state == WAIT_ACK && ack_valid && ack_bit == seq_bit;
  // a matching ack on the expiry cycle suppresses the retransmit
  assign retx = expire && !ack_match;
  abp_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(aclk),
    .rst_n(aresetn),
    .clr(state != WAIT_ACK),
    .en(state == WAIT_ACK),
    .expire(expire)
  );
  always_comb begin
    state_nxt = accept ? SEND : last_beat ? WAIT_ACK : ack_match ? IDLE : retx ? SEND : state;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ready_en <= 1'b0;
      value <= '0;
      byte_idx <= '0;
      seq_bit <= 1'b0;
      done <= 1'b0;
      retry_count <= '0;
    end else begin
      ready_en <= 1'b1;
      done <= ack_match;
      seq_bit <= seq_bit ^ ack_match;
      if (accept) value <= send_value;
      byte_idx <= accept || retx ? '0 : beat ? byte_idx + IW'(1) : byte_idx;
      retry_count <= accept ? '0 : retx && !(&retry_count) ? retry_count + RETRY_WIDTH'(1) : retry_count;
    end
endmodule

// File: tb/tb_abp_sender_transmitter.sv
// tb_abp_sender_transmitter: randomized self-checking bench against a frame-level ABP sender model
module tb_abp_sender_transmitter;
  logic aclk = 0, aresetn = 0;
  logic send_valid = 0, m_axis_tready = 0, ack_valid = 0, ack_bit = 0;
  logic [63:0] send_value = '0;
  logic send_ready, m_axis_tvalid, m_axis_tlast, busy, seq_bit, done;
  logic [7:0] m_axis_tdata;
  logic [15:0] retry_count;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [8:0] rxq[$];
  logic seq_m = 0, rand_rdy = 0, stall = 0;
  logic [63:0] cur_v = '0;

  abp_sender_transmitter #(.TIMEOUT_CYCLES(16), .RETRY_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .send_valid(send_valid), .send_ready(send_ready), .send_value(send_value),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .ack_valid(ack_valid), .ack_bit(ack_bit),
    .busy(busy), .seq_bit(seq_bit), .done(done), .retry_count(retry_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_beat(input logic [63:0] v, input logic s, input int i);
    logic [7:0] b;
    b = i < 8 ? 8'(v >> (8 * i)) : i == 63 ? {7'b0, s} : 8'h00;
    return {i == 63, b};
  endfunction

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge aclk) begin
    if (aresetn && stall) begin
      chk("stall_valid", 64'(m_axis_tvalid), 1);
      chk("stall_beat", {m_axis_tlast, m_axis_tdata}, model_beat(cur_v, seq_m, rxq.size()));
    end
    if (aresetn && m_axis_tvalid && m_axis_tready) rxq.push_back({m_axis_tlast, m_axis_tdata});
    if (aresetn && done) done_cnt++;
    stall = aresetn && m_axis_tvalid && !m_axis_tready;
  end

  task automatic offer(input logic [63:0] v);
    int n = 0;
    cur_v = v;
    send_valid = 1;
    send_value = v;
    do begin @(negedge aclk); n++; end while (!send_ready && n < 200);
    chk("offer_ready", 64'(send_ready), 1);
    @(posedge aclk);
    #1 send_valid = 0;
  endtask

  task automatic expect_frame(input logic [63:0] v, input string tag);
    int n = 0, bad = 0;
    do begin @(posedge aclk); n++; end while (rxq.size() < 64 && n < 3000);
    #1;
    chk({tag, "_len"}, 64'(rxq.size()), 64);
    for (int i = 0; i < rxq.size(); i++)
      if (rxq[i] !== model_beat(v, seq_m, i)) bad++;
    chk({tag, "_bytes"}, 64'(bad), 0);
    rxq.delete();
  endtask

  task automatic wait_retx(input string tag);
    int n = 0;
    while (!m_axis_tvalid && n < 100) begin
      @(negedge aclk);
      if (!m_axis_tvalid) n++;
    end
    chk(tag, 64'(n), 16);
  endtask

  task automatic pulse_ack(input logic b);
    ack_valid = 1;
    ack_bit = b;
    @(posedge aclk);
    #1 ack_valid = 0;
  endtask

  task automatic finish_ack();
    pulse_ack(seq_m);
    seq_m = !seq_m;
    @(negedge aclk);
    chk("ack_done", 64'(done), 1);
    chk("ack_seq", 64'(seq_bit), 64'(seq_m));
    chk("ack_ready", 64'(send_ready), 1);
    chk("ack_busy", 64'(busy), 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic txn(input logic [63:0] v, input int mode);
    int r = 0;
    offer(v);
    expect_frame(v, "frame");
    if (mode == 1) begin
      pulse_ack(!seq_m);
      @(negedge aclk);
      chk("stale_done", 64'(done), 0);
      chk("stale_busy", 64'(busy), 1);
      chk("stale_seq", 64'(seq_bit), 64'(seq_m));
      @(posedge aclk);
      #1;
    end
    if (mode == 2) begin
      wait_retx("retx_gap");
      expect_frame(v, "retx");
      r = 1;
    end
    chk("retry", 64'(retry_count), 64'(r));
    finish_ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    logic [63:0] tv;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_tlast", 64'(m_axis_tlast), 0);
    chk("rst_tdata", 64'(m_axis_tdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_seq", 64'(seq_bit), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_retry", 64'(retry_count), 0);
    @(posedge aclk);
    #1 aresetn = 1;
    @(negedge aclk);
    chk("rel_ready_first", 64'(send_ready), 0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("rel_ready", 64'(send_ready), 1);
    @(posedge aclk);
    #1;

    txn(64'h0123_4567_89AB_CDEF, 0);
    @(negedge aclk);
    chk("done_pulse_width", 64'(done), 0);
    @(posedge aclk);
    #1;
    txn(64'hFFFF_FFFF_FFFF_FFFF, 1);

    offer(64'h0F1E_2D3C_4B5A_6978);
    n = 0;
    do begin @(posedge aclk); n++; end while (rxq.size() < 10 && n < 200);
    #1;
    d0 = done_cnt;
    pulse_ack(seq_m);
    expect_frame(cur_v, "ack_in_send");
    chk("ack_in_send_busy", 64'(busy), 1);
    chk("ack_in_send_done", 64'(done_cnt), 64'(d0));
    finish_ack();

    tv = 64'hA5C3_0F96_1234_8765;
    offer(tv);
    expect_frame(tv, "to0");
    send_valid = 1;
    send_value = ~tv;
    d0 = done_cnt;
    for (int i = 1; i <= 3; i++) begin
      wait_retx("to_gap");
      expect_frame(tv, "to_frame");
      chk("to_retry", 64'(retry_count), 64'(i));
      send_valid = 0;
    end
    chk("to_no_done", 64'(done_cnt), 64'(d0));
    finish_ack();

    offer(64'h5A5A_5A5A_0000_FFFF);
    expect_frame(cur_v, "col");
    repeat (15) @(posedge aclk);
    #1;
    pulse_ack(seq_m);
    seq_m = !seq_m;
    @(negedge aclk);
    chk("col_done", 64'(done), 1);
    chk("col_tvalid", 64'(m_axis_tvalid), 0);
    chk("col_busy", 64'(busy), 0);
    chk("col_seq", 64'(seq_bit), 64'(seq_m));
    repeat (40) @(posedge aclk);
    #1;
    chk("col_no_retx", 64'(rxq.size()), 0);
    chk("col_retry", 64'(retry_count), 0);

    rand_rdy = 1;
    for (int k = 0; k < 12; k++) txn({$urandom, $urandom}, int'($urandom_range(0, 2)));
    rand_rdy = 0;
    @(posedge aclk);
    #1;

    if (!seq_m) txn(64'h1111_2222_3333_4444, 0);
    offer(64'hDEAD_BEEF_CAFE_F00D);
    n = 0;
    do begin @(posedge aclk); n++; end while (rxq.size() < 30 && n < 500);
    #2 aresetn = 0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("mid_rst_seq", 64'(seq_bit), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_tdata", 64'(m_axis_tdata), 0);
    rxq.delete();
    seq_m = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(negedge aclk);
    chk("mid_rel_ready", 64'(send_ready), 0);
    @(posedge aclk);
    #1;
    offer(64'h8899_AABB_CCDD_EEFF);
    expect_frame(cur_v, "post_rst");
    finish_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
